// File: rtl/pair_issuer.sv
// pair_issuer: operand source and result sink for the two-stage
// max/abs-diff pipeline.
//
// A host loads up to DEPTH operand pairs into a small FIFO while the block
// is idle. A start pulse streams the buffered pairs, one per clock, onto
// out1/out2 (the pipeline's in1/in2). A tag for each issued pair travels
// through a PIPE_LAT+1 deep shift register so that the pipeline's ans is
// captured exactly when it belongs to a real pair. Each capture is reported
// as res_data/res_idx with a one-cycle res_valid strobe. After the last
// result, done pulses for one cycle and the block returns to idle.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   load_valid/ready      host handshake for one {load_a, load_b} pair
//   load_a, load_b        operands, WIDTH bits each
//   start                 pulse that begins issuing the buffered batch
//   out1, out2            registered operands to the pipeline
//   ans_in                pipeline result
//   res_valid/data/idx    tagged result stream (idx = batch position)
//   busy                  high while issuing or draining
//   done                  one-cycle pulse after the last result of a batch
//   count                 number of pairs currently buffered

module pair_issuer #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int PIPE_LAT = 2,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_a,
    input  logic [WIDTH-1:0] load_b,
    input  logic             start,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    input  logic [WIDTH-1:0] ans_in,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic [AW-1:0]    res_idx,
    output logic             busy,
    output logic             done,
    output logic [AW:0]      count
);

    localparam logic [AW:0]       DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]       CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]       CNT_ZERO  = (AW+1)'(0);
    localparam logic [AW-1:0]     PTR_ONE   = AW'(1);
    localparam logic [AW-1:0]     PTR_ZERO  = AW'(0);
    localparam logic [PIPE_LAT:0] TAGS_NONE = {(PIPE_LAT+1){1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_r;
    logic [WIDTH-1:0]  mem_a_r [DEPTH];
    logic [WIDTH-1:0]  mem_b_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [AW-1:0]     idx_r;
    logic [PIPE_LAT:0] tag_valid_r;
    logic [AW-1:0]     tag_idx_r [PIPE_LAT+1];

    logic push_s;
    logic issue_s;
    logic tags_empty_s;

    // Handshake, issue enable and status decode from the current state.
    always_comb begin
        load_ready   = (state_r == ST_IDLE) && (count < DEPTH_CNT);
        push_s       = load_valid && load_ready;
        issue_s      = (state_r == ST_ISSUE) && (count != CNT_ZERO);
        busy         = (state_r == ST_ISSUE) || (state_r == ST_DRAIN);
        tags_empty_s = (tag_valid_r == TAGS_NONE);
    end

    // Operand storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_a_r[wr_ptr_r] <= load_a;
            mem_b_r[wr_ptr_r] <= load_b;
        end
    end

    // FIFO pointers, issue registers, tag pipe, result capture and FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            idx_r       <= PTR_ZERO;
            count       <= CNT_ZERO;
            out1        <= {WIDTH{1'b0}};
            out2        <= {WIDTH{1'b0}};
            tag_valid_r <= TAGS_NONE;
            for (int i = 0; i <= PIPE_LAT; i++) begin
                tag_idx_r[i] <= PTR_ZERO;
            end
            res_valid   <= 1'b0;
            res_data    <= {WIDTH{1'b0}};
            res_idx     <= PTR_ZERO;
            done        <= 1'b0;
        end else begin
            // Pushes only happen in IDLE and pops only in ISSUE, so the
            // count never sees both in one cycle.
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
                count    <= count + CNT_ONE;
            end
            if (issue_s) begin
                out1     <= mem_a_r[rd_ptr_r];
                out2     <= mem_b_r[rd_ptr_r];
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
                count    <= count - CNT_ONE;
                idx_r    <= idx_r + PTR_ONE;
            end

            // Stage 0 of the tag pipe lines up with out1/out2; the last
            // stage lines up with the edge on which ans_in is valid.
            tag_valid_r[0] <= issue_s;
            tag_idx_r[0]   <= idx_r;
            for (int i = PIPE_LAT; i > 0; i--) begin
                tag_valid_r[i] <= tag_valid_r[i-1];
                tag_idx_r[i]   <= tag_idx_r[i-1];
            end

            res_valid <= tag_valid_r[PIPE_LAT];
            if (tag_valid_r[PIPE_LAT]) begin
                res_data <= ans_in;
                res_idx  <= tag_idx_r[PIPE_LAT];
            end

            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // A push in the same cycle counts towards the batch.
                    if (start && ((count != CNT_ZERO) || push_s)) begin
                        state_r <= ST_ISSUE;
                        idx_r   <= PTR_ZERO;
                    end
                end
                ST_ISSUE: begin
                    if (count == CNT_ONE) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Empty tag pipe means the last result has been captured.
                    if (tags_empty_s) begin
                        state_r <= ST_DONE;
                        done    <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pair_issuer.sv
// Bench for pair_issuer: drives directed batches, models the max/abs-diff
// pipeline (ans = 23 + max(a,b) - 5*|a-b|, two register stages) and checks
// the result stream through a scoreboard of expected {data, idx, cycle}.

module tb_pair_issuer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [7:0] load_a = 8'd0;
    logic [7:0] load_b = 8'd0;
    logic       start = 1'b0;
    logic [7:0] out1;
    logic [7:0] out2;
    logic [7:0] ans_in;
    logic       res_valid;
    logic [7:0] res_data;
    logic [1:0] res_idx;
    logic       busy;
    logic       done;
    logic [2:0] count;

    pair_issuer #(.WIDTH(8), .DEPTH(4), .PIPE_LAT(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_a     (load_a),
        .load_b     (load_b),
        .start      (start),
        .out1       (out1),
        .out2       (out2),
        .ans_in     (ans_in),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_idx    (res_idx),
        .busy       (busy),
        .done       (done),
        .count      (count)
    );

    always #5 clk = ~clk;

    // Model of the downstream two-stage pipeline.
    logic [7:0] p_mx = 8'd0;
    logic [7:0] p_df = 8'd0;
    logic [7:0] p_ans = 8'd0;
    always @(posedge clk) begin
        p_mx  <= (out1 > out2) ? out1 : out2;
        p_df  <= (out1 > out2) ? (out1 - out2) : (out2 - out1);
        p_ans <= 8'(23 + int'(p_mx) - 5 * int'(p_df));
    end
    assign ans_in = p_ans;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int data;
        int idx;
        int at;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every presented result/done against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        int   t;
        if (res_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got data %0d idx %0d at cycle %0d, expected none",
                         res_data, res_idx, cyc);
            end else begin
                e = exp_q.pop_front();
                check("res_data", int'(res_data), e.data);
                check("res_idx", int'(res_idx), e.idx);
                check("res_cycle", cyc, e.at);
            end
        end
        if (done) begin
            if (done_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
            end else begin
                t = done_q.pop_front();
                check("done_cycle", cyc, t);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pair(input logic [7:0] a, input logic [7:0] b);
        load_valid = 1'b1;
        load_a = a;
        load_b = b;
    endtask

    // Register expected results for a batch whose start is driven at cycle c:
    // start sampled at c+1, first launch c+2, first capture c+5.
    task automatic expect_batch(input int c, input int n, input int d0, input int d1,
                                input int d2, input int d3);
        int d[4];
        exp_t e;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        for (int i = 0; i < n; i++) begin
            e.data = d[i];
            e.idx  = i;
            e.at   = c + 5 + i;
            exp_q.push_back(e);
        end
        done_q.push_back(c + 5 + n);
    endtask

    initial begin
        int c;
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        // Reset
        rst = 1'b1;
        tick();
        tick();
        check("reset_count", int'(count), 0);
        check("reset_load_ready", int'(load_ready), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_out1", int'(out1), 0);
        check("reset_res_valid", int'(res_valid), 0);
        check("reset_done", int'(done), 0);
        rst = 1'b0;
        tick();

        // Test 1: load (1,1) with start in the same cycle
        set_pair(8'd1, 8'd1);
        start = 1'b1;
        c = cyc;
        expect_batch(c, 1, 24, 0, 0, 0);
        tick();
        load_valid = 1'b0;
        start = 1'b0;
        check("t1_busy", int'(busy), 1);
        tick();
        check("t1_out1", int'(out1), 1);
        check("t1_out2", int'(out2), 1);
        check("t1_count", int'(count), 0);
        repeat (8) tick();
        check("t1_idle_busy", int'(busy), 0);

        // Test 2: four-pair batch
        set_pair(8'd1, 8'd1);  tick();
        set_pair(8'd1, 8'd0);  tick();
        set_pair(8'd10, 8'd3); tick();
        set_pair(8'd0, 8'd0);  tick();
        load_valid = 1'b0;
        check("t2_count", int'(count), 4);
        start = 1'b1;
        c = cyc;
        expect_batch(c, 4, 24, 19, 254, 23);
        tick();
        start = 1'b0;
        repeat (12) tick();
        check("t2_count_after", int'(count), 0);

        // Test 3 + 6: full buffer, 5th pair held, start/load during ISSUE
        set_pair(8'd2, 8'd5);     tick();
        set_pair(8'd200, 8'd100); tick();
        set_pair(8'd0, 8'd255);   tick();
        set_pair(8'd8, 8'd8);     tick();
        set_pair(8'd9, 8'd9);
        tick();
        tick();
        check("t3_load_ready_full", int'(load_ready), 0);
        check("t3_count_full", int'(count), 4);
        start = 1'b1;
        c = cyc;
        expect_batch(c, 4, 13, 235, 27, 31);
        tick();
        start = 1'b0;
        tick();
        check("t6_load_ready_issue", int'(load_ready), 0);
        check("t6_busy", int'(busy), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        load_valid = 1'b0;
        repeat (12) tick();
        check("t6_count_after", int'(count), 0);
        check("t6_busy_after", int'(busy), 0);

        // Test 4: start with empty buffer is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_busy", int'(busy), 0);
        repeat (6) tick();
        check("t4_busy_later", int'(busy), 0);
        check("t4_count", int'(count), 0);

        // Test 5: reset two cycles into ISSUE
        set_pair(8'd7, 8'd9); tick();
        set_pair(8'd1, 8'd2); tick();
        set_pair(8'd3, 8'd4); tick();
        set_pair(8'd5, 8'd6); tick();
        load_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("t5_out1_launch", int'(out1), 7);
        check("t5_out2_launch", int'(out2), 9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_count_rst", int'(count), 0);
        check("t5_out1_rst", int'(out1), 0);
        check("t5_out2_rst", int'(out2), 0);
        check("t5_busy_rst", int'(busy), 0);
        check("t5_load_ready_rst", int'(load_ready), 1);
        set_pair(8'd5, 8'd2);
        tick();
        load_valid = 1'b0;
        check("t5_count_new", int'(count), 1);
        repeat (8) tick();
        start = 1'b1;
        c = cyc;
        expect_batch(c, 1, 13, 0, 0, 0);
        tick();
        start = 1'b0;

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 50 && (exp_q.size() != 0 || done_q.size() != 0); i++) begin
            tick();
        end
        repeat (4) tick();
        check("results_outstanding", exp_q.size(), 0);
        check("done_outstanding", done_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pair_issuer.md
Name: pair_issuer

Overview:
- Operand-side partner of the two-stage max/abs-diff datapath pipeline.
- Buffers a batch of 8-bit operand pairs loaded by a host, then streams one pair per clock onto the pipeline's in1/in2 inputs.
- Tracks each issued pair through the fixed pipeline latency and captures the pipeline's ans output as a tagged result stream.
- Sits between the host and that pipeline as its source and its sink.

Parameters:
- WIDTH, 8, operand/result width in bits.
- DEPTH, 4, batch buffer entries (power of 2).
- PIPE_LAT, 2, register stages between the pipeline's in1/in2 and its ans.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- load_valid  in  1  host presents a pair.
- load_ready  out  1  pair accepted on a cycle where load_valid && load_ready.
- load_a  in  WIDTH  first operand.
- load_b  in  WIDTH  second operand.
- start  in  1  single-cycle pulse that begins issuing the buffered batch.
- out1  out  WIDTH  drives pipeline in1 (registered).
- out2  out  WIDTH  drives pipeline in2 (registered).
- ans_in  in  WIDTH  pipeline ans output.
- res_valid  out  1  one-cycle strobe; res_data/res_idx valid.
- res_data  out  WIDTH  captured ans for one pair.
- res_idx  out  log2(DEPTH)  batch position (0 = first loaded) of that pair.
- busy  out  1  high in ISSUE and DRAIN.
- done  out  1  one-cycle pulse after the last result of a batch.
- count  out  log2(DEPTH)+1  pairs currently buffered.

Behaviour:
- Reset (rst high at posedge): state=IDLE; FIFO pointers=0; count=0; out1=out2=0; in-flight tag pipe cleared; res_valid=0, res_data=0, res_idx=0; done=0; busy=0. load_ready follows from state/count, so it is 1 after reset.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - load_ready = (count<DEPTH).
  - Each accepted load pushes {a,b} and increments count.
  - start with count==0 (including any same-cycle push) is ignored.
  - start with count>0 -> ISSUE. A push in the same cycle as start is accepted and is part of the batch.
  - When full, load_ready=0 and load_valid is ignored.
- ISSUE:
  - load_ready=0.
  - Each cycle pop one pair; register it to out1/out2; push tag {valid=1, idx} into a PIPE_LAT+1 deep shift register. idx counts 0,1,2,... from batch start.
  - When the last pair is popped (count 1->0) -> DRAIN.
  - start is ignored outside IDLE.
- Latency: a pair launched on out1/out2 at edge t has ans_in sampled at edge t+PIPE_LAT+1. On that same edge res_data<=ans_in, res_idx<=tag idx, res_valid<=1. res_valid deasserts on the next edge unless another tag is due.
- Throughput: back-to-back results, one per cycle, with no gaps for a full batch.
- out1/out2 hold their last issued values when not issuing. Results from non-tagged cycles are never reported.
- DRAIN: load_ready=0. Wait until the tag shift register is empty (last result captured), then -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE.
- busy = state in {ISSUE, DRAIN}.
- Arithmetic: idx wraps modulo DEPTH. No arithmetic is performed on data; ans_in is passed through unmodified.
- Reset mid-batch: buffered and in-flight pairs are discarded. No res_valid or done is emitted for pre-reset pairs.

Test Plan:
- Reset, then load (1,1) and pulse start in the same cycle, against the real pipeline -> out1=out2=1 after the next edge; res_valid with res_data=24, res_idx=0 exactly PIPE_LAT+1 edges after launch; done one cycle later.
- Load (1,1),(1,0),(10,3),(0,0), then start -> four consecutive res_valid cycles: (24,0), (19,1), (254,2), (23,3); then one done pulse.
- Load 4 pairs, then hold load_valid for a 5th -> load_ready=0, count stays 4; the 5th pair is never issued.
- start with an empty buffer -> state stays IDLE; no res_valid, no done.
- Load 4 pairs, start, assert rst two cycles into ISSUE -> count=0, out1=out2=0, no further res_valid, no done; a new load is accepted the cycle after reset.
- During ISSUE, assert load_valid and pulse start -> load_ready=0, nothing is pushed, batch results unchanged.
